dly_fine_ctrl: RTL and testbench
================================

Name: dly_fine_ctrl

Overview:
- Closed-loop controller for the 64-cell fine delay chain; drives the chain's 64-bit per-cell select bus as a thermometer code.
- Integrates early/late pulses from the phase detector through a digital loop filter and steps the delay code up or down.
- Reports lock and end-of-range status.
- Supports a direct code load for calibration and bring-up.

Parameters:
- N_TAP, 64, number of fine delay cells driven; code range is 0..N_TAP.
- CODE_W, 7, code width; must satisfy 2^CODE_W > N_TAP.
- FILT_TH, 4, loop-filter threshold (1..15); net pulses required for one step.
- LOCK_CNT, 8, number of consecutive direction reversals that declares lock, and number of consecutive same-direction steps that declares unlock.
- INIT_CODE, 32, code after reset.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous reset, active-high
- i_en  input  1  loop enable
- i_up  input  1  phase detector: increase delay (one-cycle qualifier)
- i_dn  input  1  phase detector: decrease delay
- i_load  input  1  load strobe for i_load_code
- i_load_code  input  CODE_W  code to load; values above N_TAP clamp to N_TAP
- o_sel  output  N_TAP  thermometer select, o_sel[k]=1 iff k < o_code; connects to the delay-chain select bus
- o_code  output  CODE_W  current delay code
- o_lock  output  1  loop locked
- o_min  output  1  o_code==0
- o_max  output  1  o_code==N_TAP

Behaviour:
- All outputs are registered. o_sel, o_code, o_min and o_max always update on the same edge and are mutually consistent.
- Reset (i_rst=1 at an edge):
  - o_code=INIT_CODE; o_sel has the INIT_CODE LSBs set.
  - Accumulator=0; reversal and same-direction counters=0; last-direction=none.
  - o_lock=0; state=IDLE.
  - Reset overrides everything, including reset mid-step or mid-load.
- States:
  - IDLE: i_en=0; code held; accumulator held at 0.
  - TRACK: filtering, o_lock=0.
  - LOCKED: filtering, o_lock=1.
- State transitions:
  - IDLE->TRACK when i_en=1.
  - Any state->IDLE when i_en=0 (accumulator and counters cleared, code held, o_lock=0 on the same edge).
- Priority: i_rst > i_load > i_en.
- Load (i_load=1):
  - o_code=min(i_load_code, N_TAP) on that edge, with o_sel updated on the same edge.
  - Accumulator, counters and last-direction cleared; o_lock=0.
  - Next state is TRACK if i_en=1, else IDLE. i_up/i_dn are ignored that cycle.
- Filter, in TRACK/LOCKED each cycle:
  - net = +1 for i_up&!i_dn; -1 for i_dn&!i_up; 0 if both or neither.
  - acc_next = acc + net, signed, range -FILT_TH..+FILT_TH.
  - If acc_next == +FILT_TH: up-step request. If acc_next == -FILT_TH: down-step request. Either way acc is cleared to 0 on that edge; otherwise acc = acc_next.
- Step execution, on the same edge as the request:
  - up: o_code+1 if o_code < N_TAP.
  - down: o_code-1 if o_code > 0.
  - Latency from the pulse that completes the threshold to the new o_code/o_sel is 1 clock.
- Saturation:
  - An up-request at N_TAP or a down-request at 0 leaves the code unchanged and clears acc.
  - It forces o_lock=0 and state=TRACK, and clears the reversal counter.
  - It does not update last-direction.
- Lock detection, on each executed step:
  - If its direction differs from last-direction (and last-direction != none): rev_cnt++ (saturating at LOCK_CNT), same_cnt=0.
  - Otherwise: same_cnt++ (saturating), rev_cnt=0.
  - Then last-direction = this direction.
  - TRACK->LOCKED on the edge where rev_cnt reaches LOCK_CNT.
  - LOCKED->TRACK on the edge where same_cnt reaches LOCK_CNT.
- o_sel is never non-thermometer. A code change moves exactly one select bit per step, except on load.

Test Plan:
- Reset value: assert i_rst 2 cycles, then release with i_en=0 -> o_code=32, o_sel=64'h0000_0000_FFFF_FFFF, o_lock=0, o_min=0, o_max=0; code holds while i_en=0 regardless of i_up/i_dn.
- Filter and latency: i_en=1, i_up high for 4 cycles -> o_code=33 and o_sel=64'h0000_0001_FFFF_FFFF exactly 1 clock after the 4th pulse. Alternating i_up/i_dn for 20 cycles -> no code change. i_up&i_dn together -> no accumulation.
- Saturation high: load 62, then 16 consecutive i_up pulses -> o_code reaches 64 after 8 pulses, o_max=1, o_sel=all ones, and the code holds through the remaining pulses. Same check at 0 with i_dn -> o_min=1, o_sel=0.
- Lock/unlock: from code 32, alternate 4 up / 4 down pulse groups -> o_lock rises on the edge of the 9th step (8th reversal). Then 8 down-steps in a row -> o_lock falls on the 8th.
- Load priority and clamp: assert i_load with i_load_code=100 together with i_up while LOCKED -> o_code=64, o_lock=0, acc=0 (the next 3 up pulses cause no step). i_load_code=5 -> o_sel=64'h1F.
- Reset and disable mid-operation: with acc=3 pending, assert i_rst or drop i_en -> no step occurs. After reset the code is 32. After re-enable, 4 fresh pulses are needed for the next step.

Source files
------------

// File: rtl/dly_fine_ctrl.sv
// Fine delay-chain controller: filters phase-detector pulses into up/down
// steps on a thermometer-coded select bus, with lock and end-of-range status.
module dly_fine_ctrl #(
    parameter int unsigned N_TAP     = 64,
    parameter int unsigned CODE_W    = 7,
    parameter int unsigned FILT_TH   = 4,
    parameter int unsigned LOCK_CNT  = 8,
    parameter int unsigned INIT_CODE = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_up,
    input  logic              i_dn,
    input  logic              i_load,
    input  logic [CODE_W-1:0] i_load_code,
    output logic [N_TAP-1:0]  o_sel,
    output logic [CODE_W-1:0] o_code,
    output logic              o_lock,
    output logic              o_min,
    output logic              o_max
);

    // Accumulator holds -FILT_TH..+FILT_TH; 5 signed bits cover FILT_TH up to 15.
    localparam int unsigned ACC_W = 5;
    localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);

    localparam logic signed [ACC_W-1:0] TH_P   = ACC_W'(FILT_TH);
    localparam logic signed [ACC_W-1:0] TH_N   = -TH_P;
    localparam logic [CNT_W-1:0]        LOCK_C = CNT_W'(LOCK_CNT);
    localparam logic [CODE_W-1:0]       CODE_MAX  = CODE_W'(N_TAP);
    localparam logic [CODE_W-1:0]       CODE_INIT = CODE_W'(INIT_CODE);

    typedef enum logic [1:0] {StIdle, StTrack, StLocked} state_e;
    typedef enum logic [1:0] {DirNone, DirUp, DirDn} dir_e;

    function automatic logic [N_TAP-1:0] therm(input logic [CODE_W-1:0] code);
        logic [N_TAP-1:0] s;
        for (int k = 0; k < N_TAP; k++) begin
            s[k] = (CODE_W'(k) < code);
        end
        return s;
    endfunction

    state_e                   state_q, state_d;
    dir_e                     dir_q, dir_d, step_dir;
    logic [CODE_W-1:0]        code_q, code_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum, net;
    logic [CNT_W-1:0]         rev_q, rev_d, same_q, same_d;
    logic [N_TAP-1:0]         sel_q, sel_d;
    logic                     lock_q, lock_d, min_q, min_d, max_q, max_d;
    logic                     req_up, req_dn, can_step;

    // Next-state: load beats enable; filtering only runs in TRACK/LOCKED.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        code_d   = code_q;
        acc_d    = acc_q;
        rev_d    = rev_q;
        same_d   = same_q;
        net      = '0;
        if (i_up && !i_dn) net = ACC_W'(1);
        if (i_dn && !i_up) net = {ACC_W{1'b1}};
        acc_sum  = acc_q + net;
        req_up   = (acc_sum == TH_P);
        req_dn   = (acc_sum == TH_N);
        step_dir = req_up ? DirUp : DirDn;
        can_step = req_up ? (code_q < CODE_MAX) : (code_q != '0);

        if (i_load) begin
            code_d  = (i_load_code > CODE_MAX) ? CODE_MAX : i_load_code;
            acc_d   = '0;
            rev_d   = '0;
            same_d  = '0;
            dir_d   = DirNone;
            state_d = i_en ? StTrack : StIdle;
        end else if (!i_en) begin
            acc_d   = '0;
            rev_d   = '0;
            same_d  = '0;
            dir_d   = DirNone;
            state_d = StIdle;
        end else if (state_q == StIdle) begin
            state_d = StTrack;
        end else begin
            acc_d = acc_sum;
            if (req_up || req_dn) begin
                acc_d = '0;
                if (!can_step) begin
                    // End of range: drop lock but remember the last real step.
                    state_d = StTrack;
                    rev_d   = '0;
                end else begin
                    code_d = req_up ? code_q + CODE_W'(1) : code_q - CODE_W'(1);
                    if (dir_q != DirNone && step_dir != dir_q) begin
                        rev_d  = (rev_q == LOCK_C) ? rev_q : rev_q + CNT_W'(1);
                        same_d = '0;
                    end else begin
                        same_d = (same_q == LOCK_C) ? same_q : same_q + CNT_W'(1);
                        rev_d  = '0;
                    end
                    dir_d = step_dir;
                    if (state_q == StTrack && rev_d == LOCK_C) begin
                        state_d = StLocked;
                    end else if (state_q == StLocked && same_d == LOCK_C) begin
                        state_d = StTrack;
                    end
                end
            end
        end

        sel_d  = therm(code_d);
        min_d  = (code_d == '0);
        max_d  = (code_d == CODE_MAX);
        lock_d = (state_d == StLocked);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            dir_q   <= DirNone;
            code_q  <= CODE_INIT;
            acc_q   <= '0;
            rev_q   <= '0;
            same_q  <= '0;
            sel_q   <= therm(CODE_INIT);
            lock_q  <= 1'b0;
            min_q   <= (CODE_INIT == '0);
            max_q   <= (CODE_INIT == CODE_MAX);
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            code_q  <= code_d;
            acc_q   <= acc_d;
            rev_q   <= rev_d;
            same_q  <= same_d;
            sel_q   <= sel_d;
            lock_q  <= lock_d;
            min_q   <= min_d;
            max_q   <= max_d;
        end
    end

    assign o_sel  = sel_q;
    assign o_code = code_q;
    assign o_lock = lock_q;
    assign o_min  = min_q;
    assign o_max  = max_q;

endmodule

// File: tb/tb_dly_fine_ctrl.sv
// Scoreboard bench for dly_fine_ctrl: stimulus queues the expected state after
// each edge; a negedge monitor pops and compares.
module tb_dly_fine_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst, i_en, i_up, i_dn, i_load;
    logic [6:0]  i_load_code;
    logic [63:0] o_sel;
    logic [6:0]  o_code;
    logic        o_lock, o_min, o_max;

    dly_fine_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_up        (i_up),
        .i_dn        (i_dn),
        .i_load      (i_load),
        .i_load_code (i_load_code),
        .o_sel       (o_sel),
        .o_code      (o_code),
        .o_lock      (o_lock),
        .o_min       (o_min),
        .o_max       (o_max)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int    due;
        int    code;
        bit    lock;
        string name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge i_clk) cyc++;

    function automatic logic [63:0] model_sel(input int code);
        logic [63:0] s = '0;
        for (int k = 0; k < code; k++) s[k] = 1'b1;
        return s;
    endfunction

    // Monitor: compare every expectation that has come due.
    always @(negedge i_clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (o_code !== 7'(e.code) || o_lock !== e.lock || o_sel !== model_sel(e.code) ||
                o_min !== (e.code == 0) || o_max !== (e.code == 64)) begin
                failures++;
                $display("FAIL %s cyc=%0d: got code=%0d lock=%b sel=%h min=%b max=%b, want code=%0d lock=%b sel=%h min=%b max=%b",
                         e.name, cyc, o_code, o_lock, o_sel, o_min, o_max,
                         e.code, e.lock, model_sel(e.code), e.code == 0, e.code == 64);
            end
        end
    end

    task automatic step(input string nm, input int code, input bit lock);
        exp_t e;
        e.due  = cyc + 1;
        e.code = code;
        e.lock = lock;
        e.name = nm;
        q.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    // Load 32, then 9 alternating 4-pulse groups starting downward; locks on the 9th step.
    task automatic do_lock();
        i_load = 1'b1;
        i_load_code = 7'd32;
        step("lk_load", 32, 1'b0);
        i_load = 1'b0;
        for (int g = 0; g < 9; g++) begin
            i_dn = (g % 2 == 0);
            i_up = !i_dn;
            repeat (3) step("lk_grp", (g % 2 == 1) ? 31 : 32, 1'b0);
            step("lk_step", (g % 2 == 0) ? 31 : 32, g == 8);
        end
        i_up = 1'b0;
        i_dn = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_up = 1'b0; i_dn = 1'b0;
        i_load = 1'b0; i_load_code = '0;
        step("reset", 32, 1'b0);
        step("reset", 32, 1'b0);
        i_rst = 1'b0;
        i_up = 1'b1;
        repeat (3) step("idle_hold_up", 32, 1'b0);
        i_up = 1'b0; i_dn = 1'b1;
        repeat (2) step("idle_hold_dn", 32, 1'b0);
        i_dn = 1'b0;

        i_en = 1'b1;
        step("enable", 32, 1'b0);
        i_up = 1'b1;
        repeat (3) step("filt_pending", 32, 1'b0);
        step("first_step", 33, 1'b0);
        for (int i = 0; i < 20; i++) begin
            i_up = (i % 2 == 0);
            i_dn = !i_up;
            step("alternate", 33, 1'b0);
        end
        i_up = 1'b1; i_dn = 1'b1;
        repeat (5) step("both", 33, 1'b0);
        i_up = 1'b0; i_dn = 1'b0;

        i_load = 1'b1; i_load_code = 7'd62;
        step("load62", 62, 1'b0);
        i_load = 1'b0;
        i_up = 1'b1;
        for (int p = 1; p <= 16; p++) step("sat_hi", 62 + ((p / 4 > 2) ? 2 : p / 4), 1'b0);
        i_up = 1'b0;
        i_load = 1'b1; i_load_code = 7'd2;
        step("load2", 2, 1'b0);
        i_load = 1'b0;
        i_dn = 1'b1;
        for (int p = 1; p <= 16; p++) step("sat_lo", 2 - ((p / 4 > 2) ? 2 : p / 4), 1'b0);
        i_dn = 1'b0;

        do_lock();
        i_up = 1'b1;
        repeat (3) step("locked_pend", 31, 1'b1);
        i_load = 1'b1; i_load_code = 7'd100;
        step("load_clamp", 64, 1'b0);
        i_load = 1'b0;
        repeat (3) step("post_load", 64, 1'b0);
        i_up = 1'b0;
        i_load = 1'b1; i_load_code = 7'd5;
        step("load5", 5, 1'b0);
        i_load = 1'b0;
        i_up = 1'b1;
        repeat (3) step("load_acc_clr", 5, 1'b0);
        step("load_then_step", 6, 1'b0);
        i_up = 1'b0;

        do_lock();
        i_dn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            repeat (3) step("unlk_grp", 31 - k, 1'b1);
            step("unlk_step", 30 - k, k < 7);
        end
        i_dn = 1'b0;

        i_up = 1'b1;
        repeat (3) step("pre_rst", 23, 1'b0);
        i_rst = 1'b1;
        step("rst_mid", 32, 1'b0);
        i_rst = 1'b0; i_up = 1'b0;
        step("post_rst_en", 32, 1'b0);
        i_up = 1'b1;
        repeat (3) step("post_rst_acc", 32, 1'b0);
        step("post_rst_step", 33, 1'b0);
        i_up = 1'b0; i_dn = 1'b1;
        repeat (3) step("pre_dis", 33, 1'b0);
        i_en = 1'b0;
        step("disable", 33, 1'b0);
        i_en = 1'b1; i_dn = 1'b0;
        step("reenable", 33, 1'b0);
        i_dn = 1'b1;
        repeat (3) step("reen_acc", 33, 1'b0);
        step("reen_step", 32, 1'b0);
        i_dn = 1'b0;

        repeat (2) @(negedge i_clk);
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", q.size());
            checks += q.size();
            failures += q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
